// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
// Bundles the fetch port, the load/store port, the shared memory port and
// the pipeline stall line of the instruction/data memory arbiter.
//   slave  modport : seen by the arbiter (takes requests, drives acks/mem_*)
//   master modport : seen by the pipeline stages and memory model
// Ports carried:
//   inst_req/inst_addr -> inst_ack/inst_rdata              fetch stage
//   data_req/data_we/data_addr/data_wdata -> data_ack/data_rdata   load/store
//   mem_ce/mem_we/mem_addr/mem_wdata -> mem_rdata          single-port memory
//   stall                                                  pipeline hold
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_ack;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_ack;
    logic [DW-1:0] data_rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        output inst_ack, inst_rdata, data_ack, data_rdata,
        output mem_ce, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        input  inst_ack, inst_rdata, data_ack, data_rdata,
        input  mem_ce, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
// Shares one single-port memory between instruction fetch and load/store.
// Each granted access is registered onto mem_*, held for LATENCY cycles, and
// completed with a one-cycle ack (plus registered read data) to its owner.
// A starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants made while a fetch was also waiting.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imem_port_arbiter_if.slave (fetch, load/store, memory, stall)
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_port_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAT_C   = 4'(LATENCY);
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic       OWN_INST = 1'b0;
    localparam logic       OWN_DATA = 1'b1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;
    logic [3:0]    r_wait_cnt;
    logic [3:0]    r_starve_cnt;
    logic          r_inst_ack;
    logic          r_data_ack;
    logic [DW-1:0] r_inst_rdata;
    logic [DW-1:0] r_data_rdata;
    logic          r_mem_ce;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_inst_elig;
    logic          w_data_elig;
    logic          w_both_elig;
    logic          w_grant;
    logic          w_grant_data;
    logic          w_done;

    // A requester still showing req during its own ack cycle is releasing it,
    // so it is not eligible for a fresh grant in that cycle.
    assign w_inst_elig = bus.inst_req & ~r_inst_ack;
    assign w_data_elig = bus.data_req & ~r_data_ack;
    assign w_both_elig = w_inst_elig & w_data_elig;

    // Arbitration and next-state decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_both_elig) begin
                    w_grant      = 1'b1;
                    w_grant_data = (r_starve_cnt < LIMIT_C);
                    w_state_nxt  = ST_BUSY;
                end else if (w_data_elig) begin
                    w_grant      = 1'b1;
                    w_grant_data = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end else if (w_inst_elig) begin
                    w_grant      = 1'b1;
                    w_grant_data = 1'b0;
                    w_state_nxt  = ST_BUSY;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_wait_cnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory port, wait/starve counters, acks and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_INST;
            r_wait_cnt   <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            // Acks are single-cycle pulses unless re-asserted below.
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;
            if (w_grant) begin
                r_owner    <= w_grant_data ? OWN_DATA : OWN_INST;
                r_mem_ce   <= 1'b1;
                r_mem_we   <= w_grant_data & bus.data_we;
                r_mem_addr <= w_grant_data ? bus.data_addr : bus.inst_addr;
                r_mem_wdata <= w_grant_data ? bus.data_wdata : '0;
                r_wait_cnt <= LAT_C;
                // Only a data win over a waiting fetch counts toward starvation;
                // the limit check in arbitration keeps the count saturated.
                if (!w_grant_data) begin
                    r_starve_cnt <= 4'd0;
                end else if (w_both_elig) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end else begin
                    r_starve_cnt <= r_starve_cnt;
                end
            end else if (w_done) begin
                r_mem_ce   <= 1'b0;
                r_mem_we   <= 1'b0;
                r_wait_cnt <= 4'd0;
                if (r_owner == OWN_DATA) begin
                    r_data_ack <= 1'b1;
                    if (!r_mem_we) begin
                        r_data_rdata <= bus.mem_rdata;
                    end else begin
                        r_data_rdata <= r_data_rdata;
                    end
                end else begin
                    r_inst_ack   <= 1'b1;
                    r_inst_rdata <= bus.mem_rdata;
                end
            end else if (r_state == ST_BUSY) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    assign bus.inst_ack   = r_inst_ack;
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_ack   = r_data_ack;
    assign bus.data_rdata = r_data_rdata;
    assign bus.mem_ce     = r_mem_ce;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    // Hold the pipeline while either stage has an outstanding request.
    assign bus.stall      = (bus.inst_req & ~r_inst_ack) | (bus.data_req & ~r_data_ack);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
// Three arbiter instances (LATENCY 1, 3, 4; STARVE_LIMIT 4) with directed
// stimulus, a transaction-level reference model and hand-computed checks.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;
    localparam int NI  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        inst_req_a   [NI];
    logic [31:0] inst_addr_a  [NI];
    logic        data_req_a   [NI];
    logic        data_we_a    [NI];
    logic [31:0] data_addr_a  [NI];
    logic [31:0] data_wdata_a [NI];
    logic        inst_ack_a   [NI];
    logic [31:0] inst_rdata_a [NI];
    logic        data_ack_a   [NI];
    logic [31:0] data_rdata_a [NI];
    logic        mem_ce_a     [NI];
    logic        mem_we_a     [NI];
    logic [31:0] mem_addr_a   [NI];
    logic [31:0] mem_wdata_a  [NI];
    logic        stall_a      [NI];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0008)      return 32'h1080_0003;
        else if (a == 32'h0000_0028) return 32'h0000_1234;
        else                         return a ^ 32'hDEAD_0000;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        imem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        assign bus.inst_req   = inst_req_a[g];
        assign bus.inst_addr  = inst_addr_a[g];
        assign bus.data_req   = data_req_a[g];
        assign bus.data_we    = data_we_a[g];
        assign bus.data_addr  = data_addr_a[g];
        assign bus.data_wdata = data_wdata_a[g];
        assign bus.mem_rdata  = mem_fn(bus.mem_addr);
        assign inst_ack_a[g]   = bus.inst_ack;
        assign inst_rdata_a[g] = bus.inst_rdata;
        assign data_ack_a[g]   = bus.data_ack;
        assign data_rdata_a[g] = bus.data_rdata;
        assign mem_ce_a[g]     = bus.mem_ce;
        assign mem_we_a[g]     = bus.mem_we;
        assign mem_addr_a[g]   = bus.mem_addr;
        assign mem_wdata_a[g]  = bus.mem_wdata;
        assign stall_a[g]      = bus.stall;
        imem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(LIM), .AW(AW), .DW(DW)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d] actual=%h required=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          cyc = 0;
    bit          m_busy   [NI];
    int          m_gcyc   [NI];
    bit          m_own_d  [NI];
    bit          m_we     [NI];
    logic [31:0] m_addr   [NI];
    logic [31:0] m_wdata  [NI];
    bit          m_iack   [NI];
    bit          m_dack   [NI];
    logic [31:0] m_irdata [NI];
    logic [31:0] m_drdata [NI];
    int          m_starve [NI];
    byte         glog[$];

    function automatic bit elig_i(input int k);
        return inst_req_a[k] && !m_iack[k];
    endfunction
    function automatic bit elig_d(input int k);
        return data_req_a[k] && !m_dack[k];
    endfunction
    function automatic bit dwin(input int k);
        return elig_d(k) && (!elig_i(k) || (m_starve[k] < LIM));
    endfunction

    // Model: an access granted at edge G occupies memory until edge G+LATENCY,
    // after which its owner sees the ack for one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                m_busy[k] <= 1'b0; m_gcyc[k] <= 0; m_own_d[k] <= 1'b0; m_we[k] <= 1'b0;
                m_addr[k] <= 32'd0; m_wdata[k] <= 32'd0; m_iack[k] <= 1'b0; m_dack[k] <= 1'b0;
                m_irdata[k] <= 32'd0; m_drdata[k] <= 32'd0; m_starve[k] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < NI; k++) begin
                m_iack[k] <= 1'b0;
                m_dack[k] <= 1'b0;
                if (m_busy[k]) begin
                    if (cyc + 1 - m_gcyc[k] == lat_of(k)) begin
                        m_busy[k] <= 1'b0;
                        if (m_own_d[k]) begin
                            m_dack[k] <= 1'b1;
                            if (!m_we[k]) m_drdata[k] <= mem_fn(m_addr[k]);
                        end else begin
                            m_iack[k]   <= 1'b1;
                            m_irdata[k] <= mem_fn(m_addr[k]);
                        end
                    end
                end else if (elig_i(k) || elig_d(k)) begin
                    m_busy[k]  <= 1'b1;
                    m_gcyc[k]  <= cyc + 1;
                    m_own_d[k] <= dwin(k);
                    m_addr[k]  <= dwin(k) ? data_addr_a[k] : inst_addr_a[k];
                    m_we[k]    <= dwin(k) && data_we_a[k];
                    m_wdata[k] <= dwin(k) ? data_wdata_a[k] : 32'd0;
                    if (!dwin(k))                     m_starve[k] <= 0;
                    else if (elig_i(k) && elig_d(k))  m_starve[k] <= m_starve[k] + 1;
                    if (k == 0) glog.push_back(dwin(k) ? 8'h44 : 8'h49);
                end
            end
        end
    end

    // Compare every DUT output against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < NI; k++) begin
                chk("mem_ce", k, 32'(mem_ce_a[k]), 32'(m_busy[k]));
                chk("mem_we", k, 32'(mem_we_a[k]), 32'(m_busy[k] && m_we[k]));
                chk("mem_addr", k, mem_addr_a[k], m_addr[k]);
                chk("mem_wdata", k, mem_wdata_a[k], m_wdata[k]);
                chk("inst_ack", k, 32'(inst_ack_a[k]), 32'(m_iack[k]));
                chk("data_ack", k, 32'(data_ack_a[k]), 32'(m_dack[k]));
                chk("inst_rdata", k, inst_rdata_a[k], m_irdata[k]);
                chk("data_rdata", k, data_rdata_a[k], m_drdata[k]);
                chk("stall", k, 32'(stall_a[k]),
                    32'((inst_req_a[k] && !m_iack[k]) || (data_req_a[k] && !m_dack[k])));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for an ack; returns at the negedge of the ack cycle.
    task automatic wait_ack(input int k, input bit is_d, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? data_ack_a[k] : inst_ack_a[k];
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s [inst %0d] actual=no ack required=ack within 20 cycles", nm, k);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_cnt;
        byte exp_g [7];
        exp_g = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44, 8'h44};
        for (int k = 0; k < NI; k++) begin
            inst_req_a[k] = 1'b0; inst_addr_a[k] = 32'd0; data_req_a[k] = 1'b0;
            data_we_a[k] = 1'b0; data_addr_a[k] = 32'd0; data_wdata_a[k] = 32'd0;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            chk("rst_mem_ce", k, 32'(mem_ce_a[k]), 32'd0);
            chk("rst_mem_addr", k, mem_addr_a[k], 32'd0);
            chk("rst_inst_ack", k, 32'(inst_ack_a[k]), 32'd0);
            chk("rst_data_rdata", k, data_rdata_a[k], 32'd0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset during a LATENCY=3 fetch.
        step(); inst_addr_a[1] = 32'h20; inst_req_a[1] = 1'b1;
        step(); step();
        chk("t1_busy_ce", 1, 32'(mem_ce_a[1]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_ce", 1, 32'(mem_ce_a[1]), 32'd0);
        chk("t1_rst_addr", 1, mem_addr_a[1], 32'd0);
        chk("t1_rst_we", 1, 32'(mem_we_a[1]), 32'd0);
        chk("t1_rst_ack", 1, 32'(inst_ack_a[1]), 32'd0);
        chk("t1_rst_rdata", 1, inst_rdata_a[1], 32'd0);
        inst_req_a[1] = 1'b0;
        step(); step(); rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t1_no_ack", 1, 32'(inst_ack_a[1]), 32'd0);
        end
        step(); inst_addr_a[1] = 32'h24; inst_req_a[1] = 1'b1;
        wait_ack(1, 1'b0, "t1_regrant_ack");
        chk("t1_regrant_rdata", 1, inst_rdata_a[1], 32'hDEAD_0024);
        step(); inst_req_a[1] = 1'b0;

        // Single fetch, LATENCY=1.
        step(); inst_addr_a[0] = 32'h8; inst_req_a[0] = 1'b1;
        @(negedge clk);
        chk("t2_c0_stall", 0, 32'(stall_a[0]), 32'd1);
        chk("t2_c0_ce", 0, 32'(mem_ce_a[0]), 32'd0);
        @(negedge clk);
        chk("t2_c1_ce", 0, 32'(mem_ce_a[0]), 32'd1);
        chk("t2_c1_addr", 0, mem_addr_a[0], 32'h8);
        chk("t2_c1_stall", 0, 32'(stall_a[0]), 32'd1);
        @(negedge clk);
        chk("t2_c2_ack", 0, 32'(inst_ack_a[0]), 32'd1);
        chk("t2_c2_rdata", 0, inst_rdata_a[0], 32'h1080_0003);
        chk("t2_c2_stall", 0, 32'(stall_a[0]), 32'd0);
        step(); inst_req_a[0] = 1'b0;

        // Simultaneous fetch and load: data first, fetch right after.
        step();
        inst_addr_a[0] = 32'h0;  inst_req_a[0] = 1'b1;
        data_addr_a[0] = 32'h28; data_we_a[0] = 1'b0; data_req_a[0] = 1'b1;
        wait_ack(0, 1'b1, "t3_data_ack");
        chk("t3_inst_not_first", 0, 32'(inst_ack_a[0]), 32'd0);
        chk("t3_data_rdata", 0, data_rdata_a[0], 32'h0000_1234);
        step(); data_req_a[0] = 1'b0;
        @(negedge clk);
        chk("t3_fetch_ce", 0, 32'(mem_ce_a[0]), 32'd1);
        chk("t3_fetch_addr", 0, mem_addr_a[0], 32'h0);
        wait_ack(0, 1'b0, "t3_inst_ack");
        chk("t3_inst_rdata", 0, inst_rdata_a[0], 32'hDEAD_0000);
        step(); inst_req_a[0] = 1'b0;

        // Store.
        step();
        data_addr_a[0] = 32'h1000; data_wdata_a[0] = 32'hAAAA_AAAA;
        data_we_a[0] = 1'b1; data_req_a[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_mem_we", 0, 32'(mem_we_a[0]), 32'd1);
        chk("t5_mem_wdata", 0, mem_wdata_a[0], 32'hAAAA_AAAA);
        chk("t5_mem_addr", 0, mem_addr_a[0], 32'h1000);
        wait_ack(0, 1'b1, "t5_store_ack");
        chk("t5_rdata_kept", 0, data_rdata_a[0], 32'h0000_1234);
        step(); data_req_a[0] = 1'b0; data_we_a[0] = 1'b0;

        // Starvation: both request together each round; fetch withdraws
        // after losing, until the limit forces it through.
        glog.delete();
        for (int r = 0; r < 6; r++) begin
            step();
            inst_addr_a[0] = 32'h40 + 32'(r * 4);
            data_addr_a[0] = 32'h100 + 32'(r * 4);
            inst_req_a[0] = 1'b1; data_req_a[0] = 1'b1;
            step();
            if (r != 4) begin
                inst_req_a[0] = 1'b0;
                wait_ack(0, 1'b1, "t4_data_ack");
                step(); data_req_a[0] = 1'b0;
            end else begin
                wait_ack(0, 1'b0, "t4_forced_inst_ack");
                step(); inst_req_a[0] = 1'b0;
                wait_ack(0, 1'b1, "t4_data_after_inst_ack");
                step(); data_req_a[0] = 1'b0;
            end
            step();
        end
        chk("t4_grant_count", 0, 32'(glog.size()), 32'd7);
        for (int i = 0; i < 7 && i < glog.size(); i++)
            chk($sformatf("t4_grant_%0d", i), 0, 32'(glog[i]), 32'(exp_g[i]));

        // LATENCY=4 back-to-back fetches.
        step(); inst_addr_a[2] = 32'h0; inst_req_a[2] = 1'b1;
        for (int a = 0; a < 2; a++) begin
            ce_cnt = 0;
            for (int i = 0; i < 20 && !inst_ack_a[2]; i++) begin
                @(negedge clk);
                if (mem_ce_a[2]) begin
                    ce_cnt++;
                    chk("t6_addr_stable", 2, mem_addr_a[2], 32'(a * 4));
                end
            end
            chk("t6_ack", 2, 32'(inst_ack_a[2]), 32'd1);
            chk("t6_ce_cycles", 2, 32'(ce_cnt), 32'd4);
            chk("t6_rdata", 2, inst_rdata_a[2], 32'hDEAD_0000 | 32'(a * 4));
            step(); inst_addr_a[2] = 32'h4;
        end
        inst_req_a[2] = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
